// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer port scheduler.
package fb_pkg;

  localparam int unsigned DEPTH     = 307200;
  localparam int unsigned AW        = 19;
  localparam int unsigned DW        = 12;
  localparam int unsigned RD_LAT    = 3;
  localparam int unsigned FLUSH_CYC = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = write, bit 1 = read.
module fb_rr_arb2
  import fb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

  logic last_wr_q, last_wr_d;

  // On contention the side that did not win last time gets the port.
  always_comb begin
    gnt_c_o   = 2'b00;
    last_wr_d = last_wr_q;
    if (req_i[0] && (!req_i[1] || !last_wr_q)) begin
      gnt_c_o[0] = 1'b1;
      last_wr_d  = 1'b1;
    end else if (req_i[1]) begin
      gnt_c_o[1] = 1'b1;
      last_wr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_wr_q <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end

endmodule

// File: rtl/fb_port_scheduler.sv
// Time-shares the single framebuffer port between writer and reader,
// keeping the frame-deep buffer occupancy and the flush sequence.
module fb_port_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH_P = DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_flush,
  input  logic          i_wr_req,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ack,
  input  logic          i_rd_req,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_din,
  input  logic [DW-1:0] i_mem_dout,
  output logic          o_wr_frame,
  output logic          o_rd_frame,
  output logic [AW-1:0] o_occ
);

  localparam int unsigned   PIPE_W    = RD_LAT - 1;
  localparam int unsigned   FCNT_W    = 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_P - 1);
  localparam logic [AW-1:0] FULL_OCC  = AW'(DEPTH_P);

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [AW-1:0]       occ_q, occ_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic [DW-1:0]       din_q, din_d;
  logic                wf_q, wf_d;
  logic                rf_q, rf_d;
  logic [PIPE_W-1:0]   rd_pipe_q, rd_pipe_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;

  logic                run_ok_c;
  logic [1:0]          elig_c;
  logic [1:0]          gnt_c;

  // Flush FSM: a flush pulse (re)loads a three-cycle no-grant window.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (i_flush) begin
      state_d = FLUSH;
      fcnt_d  = FCNT_W'(FLUSH_CYC - 1);
    end else if (state_q == FLUSH) begin
      if (fcnt_q == '0) begin
        state_d = RUN;
      end else begin
        fcnt_d = fcnt_q - FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign run_ok_c = (state_q == RUN) && i_en && !i_flush && !i_rst;
  assign elig_c   = {run_ok_c && i_rd_req && (occ_q != '0),
                     run_ok_c && i_wr_req && (occ_q < FULL_OCC)};

  fb_rr_arb2 u_arb (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .req_i   (elig_c),
    .gnt_c_o (gnt_c)
  );

  assign o_wr_ack = gnt_c[0];

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    din_d      = din_q;
    wf_d       = 1'b0;
    rf_d       = 1'b0;
    rd_pipe_d  = {rd_pipe_q[PIPE_W-2:0], gnt_c[1]};
    rd_valid_d = rd_pipe_q[PIPE_W-1];
    rd_data_d  = rd_pipe_q[PIPE_W-1] ? i_mem_dout : rd_data_q;
    if (i_flush) begin
      // Reads already issued are dropped so stale pixels never surface.
      wptr_d     = '0;
      rptr_d     = '0;
      occ_d      = '0;
      rd_pipe_d  = '0;
      rd_valid_d = 1'b0;
    end else if (gnt_c[0]) begin
      addr_d = wptr_q;
      din_d  = i_wr_data;
      we_d   = 1'b1;
      wf_d   = (wptr_q == LAST_ADDR);
      wptr_d = wf_d ? '0 : wptr_q + AW'(1);
      occ_d  = occ_q + AW'(1);
    end else if (gnt_c[1]) begin
      addr_d = rptr_q;
      rf_d   = (rptr_q == LAST_ADDR);
      rptr_d = rf_d ? '0 : rptr_q + AW'(1);
      occ_d  = occ_q - AW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      wf_q       <= 1'b0;
      rf_q       <= 1'b0;
      rd_pipe_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      din_q      <= din_d;
      wf_q       <= wf_d;
      rf_q       <= rf_d;
      rd_pipe_q  <= rd_pipe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_mem_addr = addr_q;
  assign o_mem_we   = we_q;
  assign o_mem_din  = din_q;
  assign o_wr_frame = wf_q;
  assign o_rd_frame = rf_q;
  assign o_occ      = occ_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Self-checking bench: directed vector table, corner sequences and a
// transaction-level reference model for the randomized traffic.
module tb_fb_port_scheduler;
  import fb_pkg::*;

  localparam int unsigned TB_D = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_dout = '0;
  logic          wr_ack, rd_valid, mem_we, wr_frame, rd_frame;
  logic [DW-1:0] rd_data, mem_din;
  logic [AW-1:0] mem_addr, occ;

  always #5 clk = ~clk;

  fb_port_scheduler #(.DEPTH_P(TB_D)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_flush    (flush),
    .i_wr_req   (wr_req),
    .i_wr_data  (wr_data),
    .o_wr_ack   (wr_ack),
    .i_rd_req   (rd_req),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .o_mem_addr (mem_addr),
    .o_mem_we   (mem_we),
    .o_mem_din  (mem_din),
    .i_mem_dout (mem_dout),
    .o_wr_frame (wr_frame),
    .o_rd_frame (rd_frame),
    .o_occ      (occ)
  );

  // Behavioural single-port BRAM with one cycle of read latency.
  logic [DW-1:0] bram [TB_D];
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr[7:0]] <= mem_din;
    mem_dout <= bram[mem_addr[7:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: buffer contents, pointers and pending reads.
  typedef struct {
    int          due;
    logic [11:0] data;
  } rd_t;

  int          cyc = 0;
  int          occ_m, wptr_m, rptr_m, flush_left;
  bit          last_wr_m;
  logic [11:0] mem_m [TB_D];
  rd_t         pend [$];
  bit          exp_we, exp_wf, exp_rf;
  int          exp_addr;
  logic [11:0] exp_din;

  task automatic model_reset();
    occ_m = 0; wptr_m = 0; rptr_m = 0; flush_left = 0; last_wr_m = 1'b0;
    exp_we = 1'b0; exp_wf = 1'b0; exp_rf = 1'b0; exp_addr = 0; exp_din = '0;
    pend.delete();
  endtask

  initial begin
    bit fl, ew, er, gw, gr, ev;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        model_reset();
        chk("rst_ack", wr_ack, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_occ", occ, 0);
        chk("rst_rdv", rd_valid, 0);
      end else begin
        chk("m_we", mem_we, exp_we);
        chk("m_addr", mem_addr, exp_addr);
        if (exp_we) chk("m_din", mem_din, exp_din);
        chk("m_wframe", wr_frame, exp_wf);
        chk("m_rframe", rd_frame, exp_rf);
        chk("m_occ", occ, occ_m);
        ev = (pend.size() > 0) && (pend[0].due == cyc);
        chk("m_rdv", rd_valid, ev);
        if (ev) begin
          chk("m_rdata", rd_data, pend[0].data);
          void'(pend.pop_front());
        end
        fl = (flush_left > 0);
        ew = en && !flush && !fl && wr_req && (occ_m < TB_D);
        er = en && !flush && !fl && rd_req && (occ_m > 0);
        gw = ew && (!er || !last_wr_m);
        gr = er && !gw;
        chk("m_ack", wr_ack, gw);
        exp_we = gw;
        exp_wf = gw && (wptr_m == TB_D - 1);
        exp_rf = gr && (rptr_m == TB_D - 1);
        if (gw) begin
          exp_addr = wptr_m;
          exp_din = wr_data;
          mem_m[wptr_m] = wr_data;
          wptr_m = (wptr_m + 1) % TB_D;
          occ_m++;
          last_wr_m = 1'b1;
        end else if (gr) begin
          exp_addr = rptr_m;
          pend.push_back('{cyc + RD_LAT, mem_m[rptr_m]});
          rptr_m = (rptr_m + 1) % TB_D;
          occ_m--;
          last_wr_m = 1'b0;
        end
        if (flush) begin
          wptr_m = 0; rptr_m = 0; occ_m = 0; flush_left = FLUSH_CYC;
          pend.delete();
        end else if (fl) begin
          flush_left--;
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    bit          rd;
    logic [11:0] d;
    bit          ack;
    bit          we;
    int          addr;
    int          occ;
    bit          rdv;
    logic [11:0] rdd;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nack, nwf;
    bit prev_ack;
    tbl[0]  = '{1'b1, 1'b0, 12'h001, 1'b1, 1'b0, 0, 0, 1'b0, 12'h000};
    tbl[1]  = '{1'b1, 1'b0, 12'h002, 1'b1, 1'b1, 0, 1, 1'b0, 12'h000};
    tbl[2]  = '{1'b1, 1'b0, 12'h003, 1'b1, 1'b1, 1, 2, 1'b0, 12'h000};
    tbl[3]  = '{1'b1, 1'b0, 12'h004, 1'b1, 1'b1, 2, 3, 1'b0, 12'h000};
    tbl[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 3, 4, 1'b0, 12'h000};
    tbl[5]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3, 4, 1'b0, 12'h000};
    tbl[6]  = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 3, 4, 1'b0, 12'h000};
    tbl[7]  = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 0, 3, 1'b0, 12'h000};
    tbl[8]  = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1, 2, 1'b0, 12'h000};
    tbl[9]  = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 2, 1, 1'b1, 12'h001};
    tbl[10] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 3, 0, 1'b1, 12'h002};
    tbl[11] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 3, 0, 1'b1, 12'h003};
    tbl[12] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 3, 0, 1'b1, 12'h004};
    tbl[13] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3, 0, 1'b0, 12'h000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b1;

    // Four writes then drain with the reader
    for (int i = 0; i < 14; i++) begin
      wr_req = tbl[i].wr; rd_req = tbl[i].rd; wr_data = tbl[i].d;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i), wr_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].we);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_occ", i), occ, tbl[i].occ);
      chk($sformatf("tbl%0d_rdv", i), rd_valid, tbl[i].rdv);
      if (tbl[i].rdv) chk($sformatf("tbl%0d_rdd", i), rd_data, tbl[i].rdd);
      step();
    end

    // Preload 100, then both sides saturated must alternate
    wr_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = 12'($urandom);
      step();
    end
    rd_req = 1'b1;
    prev_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 12'($urandom);
      @(negedge clk);
      chk("alt_grant", wr_ack, !prev_ack);
      chk("alt_occ_band", (occ >= 99 && occ <= 101), 1);
      prev_ack = wr_ack;
      step();
    end

    // Flush, then fill to full with the reader idle
    wr_req = 1'b0; rd_req = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    wr_req = 1'b1;
    nack = 0; nwf = 0;
    for (int i = 0; i < TB_D + 8; i++) begin
      wr_data = 12'(i * 7 + 3);
      @(negedge clk);
      if (wr_ack) nack++;
      if (wr_frame) begin
        nwf++;
        chk("wframe_addr", mem_addr, TB_D - 1);
      end
      step();
    end
    @(negedge clk);
    chk("full_acks", nack, TB_D);
    chk("full_wframes", nwf, 1);
    chk("full_occ", occ, TB_D);
    chk("full_ack_off", wr_ack, 0);
    step();
    wr_req = 1'b0; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("first_rd_valid", rd_valid, 1);
    chk("first_rd_word", rd_data, 12'h003);
    step();

    // Flush with two reads in flight and 50 words buffered
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    wr_req = 1'b1;
    for (int i = 0; i < 52; i++) begin
      wr_data = 12'($urandom);
      step();
    end
    wr_req = 1'b0; rd_req = 1'b1;
    step();
    step();
    rd_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_occ", occ, 50);
    step();
    flush = 1'b0; wr_req = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk($sformatf("flush_k%0d_ack", j), wr_ack, 0);
      chk($sformatf("flush_k%0d_rdv", j), rd_valid, 0);
      chk($sformatf("flush_k%0d_occ", j), occ, 0);
      step();
    end
    @(negedge clk);
    chk("flush_k4_ack", wr_ack, 1);
    step();
    @(negedge clk);
    chk("flush_k5_we", mem_we, 1);
    chk("flush_k5_addr", mem_addr, 0);
    step();

    // Asynchronous reset between edges while reads are in flight
    rd_req = 1'b1;
    repeat (20) begin
      wr_data = 12'($urandom);
      step();
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", mem_addr, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_din", mem_din, 0);
    chk("arst_rdv", rd_valid, 0);
    chk("arst_rdd", rd_data, 0);
    chk("arst_wf", wr_frame, 0);
    chk("arst_rf", rd_frame, 0);
    chk("arst_occ", occ, 0);
    chk("arst_ack", wr_ack, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_req = 1'b0; wr_req = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_we", mem_we, 1);
    chk("post_rst_addr", mem_addr, 0);
    step();

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      wr_req  = ($urandom_range(0, 2) != 0);
      rd_req  = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 99) == 0);
      wr_data = 12'($urandom);
      step();
    end
    en = 1'b1; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
